si_matrix_display_ctrl: RTL and testbench

- Sequencer for the shared 8x8 LED matrix driver, a MAX7219-class serial device.
- Merges two row planes into one image: the ship/bullet plane (FILA0..FILA7) and the invader plane.
- After reset it runs the driver initialisation sequence, then periodically snapshots both planes and serialises eight digit-register writes.
- Sits between the game subsystems and the matrix pins. It is the only block that drives DIN/SCLK/CS.

---
 rtl/si_matrix_pkg.sv | 40 ++++
 rtl/si_matrix_display_ctrl_if.sv | 26 ++
 rtl/si_spi16_shifter.sv | 83 ++++++++
 rtl/si_matrix_display_ctrl.sv | 160 ++++++++++++++++
 tb/tb_si_matrix_display_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/si_matrix_pkg.sv
// Shared constants for the LED matrix sequencer: driver register map, word counts, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a. Holds init_word(), the fixed driver bring-up table.
package si_matrix_pkg;

    // MAX7219-class register addresses (upper byte of every 16-bit word)
    localparam logic [7:0] REG_NOOP      = 8'h00;
    localparam logic [7:0] REG_DIGIT0    = 8'h01;  // digit 1; digit n is REG_DIGIT0 + n - 1
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam logic [3:0] INIT_WORDS = 4'd5;
    localparam logic [3:0] ROW_WORDS  = 4'd8;

    typedef enum logic [2:0] {
        ST_INIT_LOAD  = 3'd0,
        ST_INIT_SEND  = 3'd1,
        ST_WAIT       = 3'd2,
        ST_SNAPSHOT   = 3'd3,
        ST_ROW_SEND   = 3'd4,
        ST_FRAME_END  = 3'd5
    } state_e;

    // Driver bring-up sequence, sent once after every reset.
    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {REG_SHUTDOWN,  8'h01};         // leave shutdown
            3'd1:    w = {REG_DECODE,    8'h00};         // raw segment data, no BCD decode
            3'd2:    w = {REG_SCANLIMIT, 8'h07};         // scan all 8 digits
            3'd3:    w = {REG_INTENSITY, 4'h0, intensity};
            default: w = {REG_TEST,      8'h00};         // display test off
        endcase
        return w;
    endfunction

endpackage

// File: rtl/si_matrix_display_ctrl_if.sv
// Pin/bus bundle between the game subsystems, the matrix sequencer and the matrix driver pins.
// Latency: n/a (wires only).
// Backpressure: none; master = sequencer (drives serial pins + status), slave = game/pin side.
interface si_matrix_display_ctrl_if;
    logic        SI_MATRIX_ENABLE_In;      // allows new frames to start
    logic [63:0] SI_MATRIX_PLANEA_InBus;   // ship/bullet rows, [8r+7:8r] = FILAr
    logic [63:0] SI_MATRIX_PLANEB_InBus;   // invader rows, same packing
    logic        SI_MATRIX_DIN_Out;        // serial data, MSB first
    logic        SI_MATRIX_SCLK_Out;       // serial clock
    logic        SI_MATRIX_CS_OutLow;      // chip select / LOAD, latches on rising edge
    logic        SI_MATRIX_BUSY_Out;       // word in flight or queued
    logic        SI_MATRIX_INITDONE_Out;   // sticky after the init sequence
    logic        SI_MATRIX_FRAMEDONE_Out;  // one-cycle pulse per completed frame

    modport master (
        input  SI_MATRIX_ENABLE_In, SI_MATRIX_PLANEA_InBus, SI_MATRIX_PLANEB_InBus,
        output SI_MATRIX_DIN_Out, SI_MATRIX_SCLK_Out, SI_MATRIX_CS_OutLow,
               SI_MATRIX_BUSY_Out, SI_MATRIX_INITDONE_Out, SI_MATRIX_FRAMEDONE_Out
    );

    modport slave (
        output SI_MATRIX_ENABLE_In, SI_MATRIX_PLANEA_InBus, SI_MATRIX_PLANEB_InBus,
        input  SI_MATRIX_DIN_Out, SI_MATRIX_SCLK_Out, SI_MATRIX_CS_OutLow,
               SI_MATRIX_BUSY_Out, SI_MATRIX_INITDONE_Out, SI_MATRIX_FRAMEDONE_Out
    );
endinterface

// File: rtl/si_spi16_shifter.sv
// 16-bit MSB-first serialiser with CLK_DIV half-period divider; ports: clk_i, rst_i, start_i, word_i -> din/sclk/cs_n, busy_o, done_o.
// Latency: 35*CLK_DIV cycles per word (32 bit half-periods, 1 CS-low tail, 2 CS-high gap); done_o in the last cycle.
// Backpressure: start_i accepted only while busy_o is low; busy_o drops in the done cycle so words chain with no gap.
module si_spi16_shifter #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] word_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        din_o,
    output logic        sclk_o,
    output logic        cs_n_o
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [5:0]    HP_LAST = 6'd34;

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    hp_q;     // half-period index within the word, 0..34
    logic [14:0]   sh_q;     // bits still to be presented; sh_q[14] is the next one
    logic          din_q, sclk_q, cs_n_q;
    logic          last;
    logic [5:0]    hp_nxt;

    assign last   = busy_q && (hp_q == HP_LAST) && (cnt_q == CNT_MAX);
    assign hp_nxt = hp_q + 6'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            hp_q   <= '0;
            sh_q   <= '0;
            din_q  <= 1'b0;
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
        end else if (start_i && !busy_o) begin
            // Also taken in the done cycle of the previous word: back-to-back framing.
            busy_q <= 1'b1;
            cnt_q  <= '0;
            hp_q   <= '0;
            sh_q   <= word_i[14:0];
            din_q  <= word_i[15];
            sclk_q <= 1'b0;
            cs_n_q <= 1'b0;
        end else if (busy_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                if (hp_q == HP_LAST) begin
                    busy_q <= 1'b0;
                end else begin
                    hp_q <= hp_nxt;
                    if (hp_nxt < 6'd32) begin
                        // even half-period = SCLK low, the only place DIN moves
                        sclk_q <= hp_nxt[0];
                        if (!hp_nxt[0]) begin
                            din_q <= sh_q[14];
                            sh_q  <= {sh_q[13:0], 1'b0};
                        end
                    end else if (hp_nxt == 6'd32) begin
                        sclk_q <= 1'b0;
                        din_q  <= 1'b0;
                    end else if (hp_nxt == 6'd33) begin
                        cs_n_q <= 1'b1;   // rising edge latches the word in the driver
                    end
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy_o = busy_q && !last;
    assign done_o = last;
    assign din_o  = din_q;
    assign sclk_o = sclk_q;
    assign cs_n_o = cs_n_q;

endmodule

// File: rtl/si_matrix_display_ctrl.sv
// LED matrix sequencer: driver init, periodic snapshot of PLANEA|PLANEB, eight digit writes per frame.
// Ports: SI_MATRIX_CLOCK_50, SI_MATRIX_RESET_InHigh, mif (enable/planes in; DIN/SCLK/CS/status out).
// Latency: frame starts 1 cycle after pending&enable; words back-to-back at 35*CLK_DIV each. No backpressure on inputs.
module si_matrix_display_ctrl
    import si_matrix_pkg::*;
#(
    parameter int         CLK_DIV       = 25,
    parameter int         REFRESH_TICKS = 500000,
    parameter logic [3:0] INTENSITY     = 4'h8
) (
    input  logic                      SI_MATRIX_CLOCK_50,
    input  logic                      SI_MATRIX_RESET_InHigh,
    si_matrix_display_ctrl_if.master  mif
);
    localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_TICKS - 1);

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;        // index of the next word to launch
    logic             pend_q, pend_d;
    logic             initdone_q, initdone_d;
    logic [RW-1:0]    refcnt_q, refcnt_d;
    logic [7:0][7:0]  rows_q, rows_d;

    logic             sh_start, sh_busy, sh_done;
    logic [15:0]      sh_word;
    logic             ref_wrap;
    logic [7:0]       digit_addr;

    assign ref_wrap = (refcnt_q == REF_MAX);

    // State register
    always_ff @(posedge SI_MATRIX_CLOCK_50 or posedge SI_MATRIX_RESET_InHigh) begin
        if (SI_MATRIX_RESET_InHigh) begin
            state_q    <= ST_WAIT;   // WAIT with initdone=0 steps straight into INIT_LOAD
            idx_q      <= '0;
            pend_q     <= 1'b0;
            initdone_q <= 1'b0;
            refcnt_q   <= '0;
            rows_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            initdone_q <= initdone_d;
            refcnt_q   <= refcnt_d;
            rows_q     <= rows_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        initdone_d = initdone_q;
        rows_d     = rows_q;
        refcnt_d   = ref_wrap ? '0 : refcnt_q + 1'b1;

        case (state_q)
            ST_WAIT: begin
                if (!initdone_q) begin
                    state_d = ST_INIT_LOAD;
                    idx_d   = '0;
                end else if (pend_q && mif.SI_MATRIX_ENABLE_In) begin
                    state_d = ST_SNAPSHOT;
                    pend_d  = 1'b0;
                end
            end
            ST_INIT_LOAD: begin
                idx_d   = 4'd1;          // word 0 launches in this cycle
                state_d = ST_INIT_SEND;
            end
            ST_INIT_SEND: begin
                if (sh_done && idx_q == INIT_WORDS) begin
                    initdone_d = 1'b1;
                    state_d    = ST_WAIT;
                end else if (!sh_busy && idx_q < INIT_WORDS) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_SNAPSHOT: begin
                for (int r = 0; r < 8; r++) begin
                    rows_d[r] = mif.SI_MATRIX_PLANEA_InBus[8*r +: 8] | mif.SI_MATRIX_PLANEB_InBus[8*r +: 8];
                end
                idx_d   = '0;
                state_d = ST_ROW_SEND;
            end
            ST_ROW_SEND: begin
                if (sh_done && idx_q == ROW_WORDS) begin
                    state_d = ST_FRAME_END;
                end else if (!sh_busy && idx_q < ROW_WORDS) begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_FRAME_END: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // A wrap always (re)arms pending, even in the cycle a frame consumes it;
        // a wrap while already pending is simply absorbed.
        if (ref_wrap) begin
            pend_d = 1'b1;
        end
    end

    // Output logic: word launch and status
    assign digit_addr = REG_DIGIT0 + {5'd0, idx_q[2:0]};

    always_comb begin
        sh_start = 1'b0;
        sh_word  = {REG_NOOP, 8'h00};
        case (state_q)
            ST_INIT_LOAD: begin
                sh_start = 1'b1;
                sh_word  = init_word(idx_q[2:0], INTENSITY);
            end
            ST_INIT_SEND: begin
                if (!sh_busy && idx_q < INIT_WORDS) begin
                    sh_start = 1'b1;
                    sh_word  = init_word(idx_q[2:0], INTENSITY);
                end
            end
            ST_ROW_SEND: begin
                if (!sh_busy && idx_q < ROW_WORDS) begin
                    sh_start = 1'b1;
                    sh_word  = {digit_addr, rows_q[idx_q[2:0]]};
                end
            end
            default: begin
                sh_start = 1'b0;
            end
        endcase
    end

    assign mif.SI_MATRIX_BUSY_Out      = (state_q != ST_WAIT);
    assign mif.SI_MATRIX_FRAMEDONE_Out = (state_q == ST_FRAME_END);
    // Rises in the same cycle as the last init word's done pulse.
    assign mif.SI_MATRIX_INITDONE_Out  = initdone_q ||
                                         (state_q == ST_INIT_SEND && sh_done && idx_q == INIT_WORDS);

    si_spi16_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_i   (SI_MATRIX_CLOCK_50),
        .rst_i   (SI_MATRIX_RESET_InHigh),
        .start_i (sh_start),
        .word_i  (sh_word),
        .busy_o  (sh_busy),
        .done_o  (sh_done),
        .din_o   (mif.SI_MATRIX_DIN_Out),
        .sclk_o  (mif.SI_MATRIX_SCLK_Out),
        .cs_n_o  (mif.SI_MATRIX_CS_OutLow)
    );

endmodule

// File: tb/tb_si_matrix_display_ctrl.sv
// Bench for si_matrix_display_ctrl: words decoded at each CS rise and matched against a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a; also measures SCLK period, word length, CS gap and DIN stability.
module tb_si_matrix_display_ctrl;
    localparam int CLK_DIV  = 2;
    localparam int REF_T    = 2000;
    localparam int WORD_LEN = 35 * CLK_DIV;

    typedef struct {
        logic [15:0] w;
        bit          b2b;   // word follows the previous one with no idle gap
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [63:0] pa  = '0;
    logic [63:0] pb  = '0;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    bit          mon_en = 1'b0;
    int          cyc = 0, cs_falls = 0, fd_cnt = 0, bitcnt = 0;
    int          last_rise = 0, last_cs_fall = 0, last_cs_rise = 0;
    bit          rise_seen = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_din = 1'b0;
    logic [15:0] shreg = '0;

    always #5 clk = ~clk;

    si_matrix_display_ctrl_if mif ();
    assign mif.SI_MATRIX_ENABLE_In    = en;
    assign mif.SI_MATRIX_PLANEA_InBus = pa;
    assign mif.SI_MATRIX_PLANEB_InBus = pb;

    si_matrix_display_ctrl #(
        .CLK_DIV       (CLK_DIV),
        .REFRESH_TICKS (REF_T),
        .INTENSITY     (4'h8)
    ) dut (
        .SI_MATRIX_CLOCK_50     (clk),
        .SI_MATRIX_RESET_InHigh (rst),
        .mif                    (mif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_init();
        logic [15:0] iw [5];
        iw = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00};
        for (int i = 0; i < 5; i++) sb.push_back('{iw[i], (i != 0)});
    endtask

    task automatic push_frame();
        for (int r = 0; r < 8; r++) begin
            logic [7:0] addr;
            addr = 8'(r + 1);
            sb.push_back('{{addr, pa[8*r +: 8] | pb[8*r +: 8]}, (r != 0)});
        end
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int budget);
        for (int i = 0; i < budget && mif.SI_MATRIX_BUSY_Out !== lvl; i++) @(negedge clk);
        check(tag, mif.SI_MATRIX_BUSY_Out, lvl);
    endtask

    task automatic wait_falls(input string tag, input int target);
        for (int i = 0; i < 3000 && cs_falls < target; i++) @(negedge clk);
        check(tag, (cs_falls >= target), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_cs"},   mif.SI_MATRIX_CS_OutLow, 1);
        check({tag, "_sclk"}, mif.SI_MATRIX_SCLK_Out, 0);
        check({tag, "_din"},  mif.SI_MATRIX_DIN_Out, 0);
        check({tag, "_busy"}, mif.SI_MATRIX_BUSY_Out, 0);
        check({tag, "_init"}, mif.SI_MATRIX_INITDONE_Out, 0);
        check({tag, "_fd"},   mif.SI_MATRIX_FRAMEDONE_Out, 0);
    endtask

    // Serial decoder and timing monitor, sampled away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (mif.SI_MATRIX_FRAMEDONE_Out === 1'b1) fd_cnt++;
        if (mon_en) begin
            if (prev_cs && !mif.SI_MATRIX_CS_OutLow) begin
                cs_falls++;
                if (sb.size() > 0 && sb[0].b2b) begin
                    check("cs_gap", cyc - last_cs_rise, 2 * CLK_DIV);
                    check("word_len", cyc - last_cs_fall, WORD_LEN);
                end
                last_cs_fall = cyc;
                bitcnt       = 0;
                rise_seen    = 1'b0;
            end
            if (!mif.SI_MATRIX_CS_OutLow && !prev_sclk && mif.SI_MATRIX_SCLK_Out) begin
                shreg = {shreg[14:0], mif.SI_MATRIX_DIN_Out};
                bitcnt++;
                if (rise_seen) check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
                last_rise = cyc;
                rise_seen = 1'b1;
            end
            if (!mif.SI_MATRIX_CS_OutLow && prev_sclk && mif.SI_MATRIX_SCLK_Out)
                check("din_stable", mif.SI_MATRIX_DIN_Out, prev_din);
            if (!prev_cs && mif.SI_MATRIX_CS_OutLow) begin
                last_cs_rise = cyc;
                check("bit_count", bitcnt, 16);
                check("word_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word", shreg, e.w);
                end
            end
        end
        prev_cs   = mif.SI_MATRIX_CS_OutLow;
        prev_sclk = mif.SI_MATRIX_SCLK_Out;
        prev_din  = mif.SI_MATRIX_DIN_Out;
    end

    initial begin
        int base, fd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outs("rst");

        // Init sequence with ENABLE low
        push_init();
        mon_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("init_busy_rise", mif.SI_MATRIX_BUSY_Out, 1);
        check("init_not_done", mif.SI_MATRIX_INITDONE_Out, 0);
        wait_busy("init_idle", 1'b0, 1000);
        check("init_done", mif.SI_MATRIX_INITDONE_Out, 1);
        check("init_sb_empty", sb.size(), 0);
        base = cs_falls;
        repeat (2500) @(negedge clk);
        check("disabled_quiet", cs_falls - base, 0);
        check("disabled_busy", mif.SI_MATRIX_BUSY_Out, 0);

        // Frame 1: pending already set, so it starts as soon as ENABLE rises
        pa[7:0]   = 8'h18;
        pb[63:56] = 8'h81;
        fd0 = fd_cnt;
        en  = 1'b1;
        wait_busy("f1_start", 1'b1, 10);
        push_frame();
        wait_busy("f1_idle", 1'b0, 1000);
        check("f1_sb_empty", sb.size(), 0);
        check("f1_framedone", fd_cnt - fd0, 1);
        check("f1_initdone_sticky", mif.SI_MATRIX_INITDONE_Out, 1);

        // Frame 2: input changes two cycles after SNAPSHOT must not leak in
        fd0 = fd_cnt;
        wait_busy("f2_start", 1'b1, 2500);
        push_frame();
        repeat (2) @(negedge clk);
        pa[7:0] = 8'hFF;
        wait_busy("f2_idle", 1'b0, 1000);
        check("f2_sb_empty", sb.size(), 0);
        check("f2_framedone", fd_cnt - fd0, 1);

        // Frame 3 picks up the new row
        wait_busy("f3_start", 1'b1, 2500);
        push_frame();
        wait_busy("f3_idle", 1'b0, 1000);
        check("f3_sb_empty", sb.size(), 0);

        // Frame 4: ENABLE dropped during the 3rd row word, frame still completes
        fd0 = fd_cnt;
        wait_busy("f4_start", 1'b1, 2500);
        push_frame();
        base = cs_falls;
        wait_falls("f4_third_word", base + 3);
        en = 1'b0;
        wait_busy("f4_idle", 1'b0, 1000);
        check("f4_sb_empty", sb.size(), 0);
        check("f4_framedone", fd_cnt - fd0, 1);
        base = cs_falls;
        repeat (3 * REF_T) @(negedge clk);
        check("f4_quiet", cs_falls - base, 0);
        check("f4_quiet_busy", mif.SI_MATRIX_BUSY_Out, 0);

        // Re-enable: pending is held, so the frame starts at once
        en = 1'b1;
        @(negedge clk);
        check("reenable_start", mif.SI_MATRIX_BUSY_Out, 1);
        push_frame();

        // Reset in the middle of a bit of the second row word
        base = cs_falls;
        wait_falls("rst_word2", base + 2);
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outs("midrst");
        en = 1'b0;
        sb.delete();
        push_init();
        repeat (3) @(negedge clk);
        check_reset_outs("midrst_hold");
        mon_en = 1'b1;
        rst    = 1'b0;
        wait_busy("reinit_start", 1'b1, 10);
        wait_busy("reinit_idle", 1'b0, 1000);
        check("reinit_sb_empty", sb.size(), 0);
        check("reinit_done", mif.SI_MATRIX_INITDONE_Out, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
